// File: rtl/i2c_eeprom_target.sv
// I2C target emulating a 24LC-series EEPROM: 16-bit word address, sequential
// writes and reads against an internal byte array, open-drain SDA.
module i2c_eeprom_target #(
  parameter logic [7:0]  DEVICE_ID = 8'hA0,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        i2c_sclk,
  inout  wire         i2c_sdat,
  output logic        wr_strobe,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);
  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam int unsigned CW = 4;

  typedef enum logic [3:0] {
    S_IDLE, S_DEV_ADDR, S_ACK_DEV, S_ADDR_HI, S_ACK_AH, S_ADDR_LO,
    S_ACK_AL, S_WR_DATA, S_ACK_WR, S_RD_DATA, S_RD_MACK, S_WAIT_STOP
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_scl_s1, r_scl_s2, r_scl_d;
  logic          r_sda_s1, r_sda_s2, r_sda_d;
  logic [CW-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [7:0]    r_addr_hi, w_addr_hi_nxt;
  logic [15:0]   r_ptr, w_ptr_nxt;
  logic          r_sda_oe, w_sda_oe_nxt;
  logic          r_ack_seen, w_ack_seen_nxt;
  logic          w_wr_en;
  logic          w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0]    w_byte, w_rd_byte;

  // Stored inverted so zero-configured RAM reads back as erased 8'hFF.
  logic [7:0]    r_mem_n [MEM_DEPTH];

  assign i2c_sdat = r_sda_oe ? 1'b0 : 1'bz;

  // Two-flop synchronizers plus one history flop per bus line.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_scl_s1 <= i2c_sclk;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= i2c_sdat;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & ~r_sda_s2 & r_sda_d;
  assign w_stop     = r_scl_s2 & r_scl_d & r_sda_s2 & ~r_sda_d;
  assign w_byte     = {r_shift[6:0], r_sda_s2};
  assign w_rd_byte  = ~r_mem_n[r_ptr[AW-1:0]];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath decode; START/STOP override byte handling.
  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_addr_hi_nxt  = r_addr_hi;
    w_ptr_nxt      = r_ptr;
    w_sda_oe_nxt   = r_sda_oe;
    w_ack_seen_nxt = r_ack_seen;
    w_wr_en        = 1'b0;
    if (w_start) begin
      w_state_nxt    = S_DEV_ADDR;
      w_bit_cnt_nxt  = '0;
      w_sda_oe_nxt   = 1'b0;
      w_ack_seen_nxt = 1'b0;
    end else if (w_stop) begin
      w_state_nxt    = S_IDLE;
      w_bit_cnt_nxt  = '0;
      w_sda_oe_nxt   = 1'b0;
      w_ack_seen_nxt = 1'b0;
    end else begin
      case (r_state)
        S_DEV_ADDR, S_ADDR_HI, S_ADDR_LO, S_WR_DATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            if (r_bit_cnt == CW'(7)) begin
              w_bit_cnt_nxt  = '0;
              w_ack_seen_nxt = 1'b0;
              case (r_state)
                S_DEV_ADDR: w_state_nxt = (w_byte[7:1] == DEVICE_ID[7:1]) ? S_ACK_DEV : S_WAIT_STOP;
                S_ADDR_HI: begin
                  w_addr_hi_nxt = w_byte;
                  w_state_nxt   = S_ACK_AH;
                end
                S_ADDR_LO: begin
                  w_ptr_nxt   = {r_addr_hi, w_byte};
                  w_state_nxt = S_ACK_AL;
                end
                default: begin
                  w_wr_en     = 1'b1;
                  w_state_nxt = S_ACK_WR;
                end
              endcase
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + CW'(1);
            end
          end
        end
        // First SCL fall drives the ACK, the 9th rise is noted, next fall releases.
        S_ACK_DEV, S_ACK_AH, S_ACK_AL, S_ACK_WR: begin
          if (w_scl_rise) begin
            w_ack_seen_nxt = 1'b1;
          end else if (w_scl_fall) begin
            if (!r_ack_seen) begin
              w_sda_oe_nxt = 1'b1;
            end else begin
              w_sda_oe_nxt   = 1'b0;
              w_ack_seen_nxt = 1'b0;
              case (r_state)
                S_ACK_DEV: begin
                  if (r_shift[0]) begin
                    w_state_nxt  = S_RD_DATA;
                    w_shift_nxt  = w_rd_byte;
                    w_sda_oe_nxt = ~w_rd_byte[7];
                  end else begin
                    w_state_nxt = S_ADDR_HI;
                  end
                end
                S_ACK_AH: w_state_nxt = S_ADDR_LO;
                S_ACK_AL: w_state_nxt = S_WR_DATA;
                default: begin
                  w_ptr_nxt   = r_ptr + 16'd1;
                  w_state_nxt = S_WR_DATA;
                end
              endcase
            end
          end
        end
        S_RD_DATA: begin
          if (w_scl_rise) begin
            w_bit_cnt_nxt = r_bit_cnt + CW'(1);
          end else if (w_scl_fall) begin
            if (r_bit_cnt == CW'(8)) begin
              w_bit_cnt_nxt  = '0;
              w_sda_oe_nxt   = 1'b0;
              w_ack_seen_nxt = 1'b0;
              w_state_nxt    = S_RD_MACK;
            end else begin
              w_shift_nxt  = {r_shift[6:0], 1'b0};
              w_sda_oe_nxt = ~r_shift[6];
            end
          end
        end
        S_RD_MACK: begin
          if (w_scl_rise) begin
            if (!r_sda_s2) begin
              w_ptr_nxt      = r_ptr + 16'd1;
              w_ack_seen_nxt = 1'b1;
            end else begin
              w_state_nxt = S_WAIT_STOP;
            end
          end else if (w_scl_fall && r_ack_seen) begin
            w_ack_seen_nxt = 1'b0;
            w_shift_nxt    = w_rd_byte;
            w_sda_oe_nxt   = ~w_rd_byte[7];
            w_state_nxt    = S_RD_DATA;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_addr_hi  <= '0;
      r_ptr      <= '0;
      r_sda_oe   <= 1'b0;
      r_ack_seen <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
    end else begin
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_addr_hi  <= w_addr_hi_nxt;
      r_ptr      <= w_ptr_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_ack_seen <= w_ack_seen_nxt;
      wr_strobe  <= w_wr_en;
      busy       <= (w_state_nxt != S_IDLE);
      if (w_wr_en) begin
        wr_addr <= r_ptr;
        wr_data <= w_byte;
      end
    end
  end

  // Storage has no reset so contents survive Reset_n.
  always_ff @(posedge Clk) begin
    if (w_wr_en) begin
      r_mem_n[r_ptr[AW-1:0]] <= ~w_byte;
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_target.sv
// Directed bench for i2c_eeprom_target: a vector table of bus operations plus
// hand-written sequences for STOP mid-byte, master NACK and reset mid-read.
module tb_i2c_eeprom_target;
  localparam int Q = 8;

  typedef enum logic [2:0] {OP_START, OP_STOP, OP_WR, OP_RD, OP_BUSY} op_e;
  typedef struct packed {
    op_e        op;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        scl = 1'b1;
  logic        m_sda_low = 1'b0;
  wire         sda_bus;
  logic        wr_strobe;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;

  int          n_checks = 0;
  int          n_err = 0;
  vec_t        vecs[$];
  logic [23:0] exp_q[$];
  logic [23:0] got_q[$];

  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  always #10 Clk = ~Clk;

  i2c_eeprom_target #(.DEVICE_ID(8'hA0), .MEM_DEPTH(256)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .i2c_sclk  (scl),
    .i2c_sdat  (sda_bus),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  always @(negedge Clk) begin
    if (wr_strobe) got_q.push_back({wr_addr, wr_data});
  end

  initial begin
    repeat (90000) @(posedge Clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge Clk);
  endtask

  task automatic do_start();
    m_sda_low = 1'b0; wait_q();
    scl = 1'b1;       wait_q();
    m_sda_low = 1'b1; wait_q();
    scl = 1'b0;
  endtask

  task automatic do_stop();
    m_sda_low = 1'b1; wait_q();
    scl = 1'b1;       wait_q();
    m_sda_low = 1'b0; wait_q();
  endtask

  task automatic clk_bit(input logic b, output logic s);
    wait_q(); m_sda_low = ~b;
    wait_q(); scl = 1'b1;
    wait_q(); s = sda_bus;
    wait_q(); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic [7:0] sh;
    logic       s;
    sh = b;
    for (int k = 0; k < 8; k++) begin
      clk_bit(sh[7], s);
      sh = {sh[6:0], 1'b0};
    end
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    logic s;
    b = '0;
    for (int k = 0; k < 8; k++) begin
      clk_bit(1'b1, s);
      b = {b[6:0], s};
    end
    clk_bit(~mack, s);
  endtask

  task automatic add(input op_e op, input logic [7:0] d, input logic [7:0] e);
    vec_t v;
    v.op = op; v.data = d; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic set_ptr(input string tag, input logic [15:0] a);
    logic ack;
    do_start();
    send_byte(8'hA0, ack); check({tag, "_hdr_ack"}, 24'(ack), 24'(1));
    send_byte(a[15:8], ack); check({tag, "_ah_ack"}, 24'(ack), 24'(1));
    send_byte(a[7:0], ack); check({tag, "_al_ack"}, 24'(ack), 24'(1));
  endtask

  task automatic read_at(input string tag, input logic [15:0] a, input logic [7:0] exp);
    logic       ack;
    logic [7:0] rb;
    set_ptr(tag, a);
    do_start();
    send_byte(8'hA1, ack); check({tag, "_rd_hdr_ack"}, 24'(ack), 24'(1));
    read_byte(1'b0, rb);
    check({tag, "_rd_data"}, 24'(rb), 24'(exp));
    do_stop();
  endtask

  initial begin
    logic        ack;
    logic        s;
    logic [7:0]  rb;
    logic [8:0]  idle_bits;
    logic [7:0]  pat [6];

    pat[0] = 8'h12; pat[1] = 8'h34; pat[2] = 8'h56;
    pat[3] = 8'h78; pat[4] = 8'h9A; pat[5] = 8'hB5;

    repeat (4) @(negedge Clk);
    check("rst_busy",    24'(busy),      24'(0));
    check("rst_strobe",  24'(wr_strobe), 24'(0));
    check("rst_wr_addr", 24'(wr_addr),   24'(0));
    check("rst_wr_data", 24'(wr_data),   24'(0));
    check("rst_sda",     24'(sda_bus),   24'(1));
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);

    // sequential write of six bytes at 0x000A
    add(OP_START, 8'h00, 8'h00); add(OP_BUSY, 8'h00, 8'h01);
    add(OP_WR, 8'hA0, 8'h01); add(OP_WR, 8'h00, 8'h01); add(OP_WR, 8'h0A, 8'h01);
    for (int i = 0; i < 6; i++) begin
      add(OP_WR, pat[i], 8'h01);
      exp_q.push_back({16'h000A + 16'(i), pat[i]});
    end
    add(OP_STOP, 8'h00, 8'h00); add(OP_BUSY, 8'h00, 8'h00);
    // random read of the same six bytes
    add(OP_START, 8'h00, 8'h00);
    add(OP_WR, 8'hA0, 8'h01); add(OP_WR, 8'h00, 8'h01); add(OP_WR, 8'h0A, 8'h01);
    add(OP_START, 8'h00, 8'h00); add(OP_WR, 8'hA1, 8'h01);
    for (int i = 0; i < 6; i++) add(OP_RD, (i < 5) ? 8'h01 : 8'h00, pat[i]);
    add(OP_STOP, 8'h00, 8'h00);
    // write across 0x00FF, then read back through the alias at index 0
    add(OP_START, 8'h00, 8'h00);
    add(OP_WR, 8'hA0, 8'h01); add(OP_WR, 8'h00, 8'h01); add(OP_WR, 8'hFF, 8'h01);
    add(OP_WR, 8'h11, 8'h01); add(OP_WR, 8'h22, 8'h01);
    add(OP_STOP, 8'h00, 8'h00);
    exp_q.push_back({16'h00FF, 8'h11});
    exp_q.push_back({16'h0100, 8'h22});
    add(OP_START, 8'h00, 8'h00);
    add(OP_WR, 8'hA0, 8'h01); add(OP_WR, 8'h00, 8'h01); add(OP_WR, 8'h00, 8'h01);
    add(OP_START, 8'h00, 8'h00); add(OP_WR, 8'hA1, 8'h01);
    add(OP_RD, 8'h00, 8'h22);
    add(OP_START, 8'h00, 8'h00);
    add(OP_WR, 8'hA0, 8'h01); add(OP_WR, 8'h00, 8'h01); add(OP_WR, 8'hFF, 8'h01);
    add(OP_START, 8'h00, 8'h00); add(OP_WR, 8'hA1, 8'h01);
    add(OP_RD, 8'h01, 8'h11); add(OP_RD, 8'h00, 8'h22);
    add(OP_STOP, 8'h00, 8'h00);
    // wrong device address: no ACK on header or following byte
    add(OP_START, 8'h00, 8'h00);
    add(OP_WR, 8'hA2, 8'h00); add(OP_BUSY, 8'h00, 8'h01); add(OP_WR, 8'h55, 8'h00);
    add(OP_STOP, 8'h00, 8'h00); add(OP_BUSY, 8'h00, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OP_START: do_start();
        OP_STOP:  do_stop();
        OP_WR: begin
          send_byte(vecs[i].data, ack);
          check($sformatf("v%0d_ack_%h", i, vecs[i].data), 24'(ack), 24'(vecs[i].exp));
        end
        OP_RD: begin
          read_byte(vecs[i].data[0], rb);
          check($sformatf("v%0d_rd", i), 24'(rb), 24'(vecs[i].exp));
        end
        OP_BUSY: begin
          wait_q();
          check($sformatf("v%0d_busy", i), 24'(busy), 24'(vecs[i].exp));
        end
        default: ;
      endcase
    end
    check("tbl_strobe_count", 24'(got_q.size()), 24'(exp_q.size()));

    // STOP after five data bits leaves memory untouched
    set_ptr("pre", 16'h0020);
    send_byte(8'h3C, ack); check("pre_data_ack", 24'(ack), 24'(1));
    do_stop();
    exp_q.push_back({16'h0020, 8'h3C});
    set_ptr("part", 16'h0020);
    clk_bit(1'b1, s); clk_bit(1'b1, s); clk_bit(1'b0, s); clk_bit(1'b0, s); clk_bit(1'b0, s);
    do_stop();
    wait_q();
    check("part_busy", 24'(busy), 24'(0));
    check("part_strobe_count", 24'(got_q.size()), 24'(exp_q.size()));
    read_at("part_rb", 16'h0020, 8'h3C);

    // master NACK: further SCL pulses see SDA released
    read_at("nack", 16'h000A, 8'h12);
    set_ptr("nack2", 16'h000A);
    do_start();
    send_byte(8'hA1, ack); check("nack2_hdr_ack", 24'(ack), 24'(1));
    read_byte(1'b0, rb); check("nack2_data", 24'(rb), 24'(8'h12));
    for (int k = 0; k < 9; k++) begin
      clk_bit(1'b1, s);
      idle_bits[k] = s;
    end
    check("nack2_released", 24'(idle_bits), 24'(9'h1FF));
    check("nack2_busy", 24'(busy), 24'(1));
    do_stop();
    wait_q();
    check("nack2_idle", 24'(busy), 24'(0));

    // reset while the target drives a 0 data bit (0x78 MSB)
    set_ptr("rr", 16'h000D);
    do_start();
    send_byte(8'hA1, ack); check("rr_hdr_ack", 24'(ack), 24'(1));
    wait_q();
    check("rr_driving", 24'(sda_bus), 24'(0));
    #3 Reset_n = 1'b0;
    #1;
    check("rr_sda_rel", 24'(sda_bus), 24'(1));
    check("rr_busy", 24'(busy), 24'(0));
    check("rr_wr_addr", 24'(wr_addr), 24'(0));
    @(negedge Clk);
    Reset_n = 1'b1;
    wait_q();
    scl = 1'b1;
    wait_q();
    set_ptr("post", 16'h0100);
    send_byte(8'h5C, ack); check("post_data_ack", 24'(ack), 24'(1));
    do_stop();
    exp_q.push_back({16'h0100, 8'h5C});
    read_at("post_alias", 16'h0000, 8'h5C);
    read_at("post_keep", 16'h000B, 8'h34);

    check("strobe_count", 24'(got_q.size()), 24'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("strobe%0d", i), got_q[i], exp_q[i]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
